// File: rtl/dcache_queue_ctrl.sv
// Two-port data-cache request queue controller: arbitrates A/B into an external queue and drains it to the backend.
// Build option: define DCACHE_QUEUE_CTRL_RR_EN for round-robin arbitration; the default is fixed priority (A first).
module dcache_queue_ctrl #(
    parameter int DATABITS     = 32,
    parameter int ADDRBITS     = 32,
    parameter int QUEUECNTBITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_rdreq,
    input  logic                    a_wrreq,
    input  logic [ADDRBITS-1:0]     a_addr,
    input  logic [DATABITS-1:0]     a_data,
    input  logic [1:0]              a_wordlen,
    output logic                    a_ack,
    input  logic                    b_rdreq,
    input  logic                    b_wrreq,
    input  logic [ADDRBITS-1:0]     b_addr,
    input  logic [DATABITS-1:0]     b_data,
    input  logic [1:0]              b_wordlen,
    output logic                    b_ack,
    output logic [DATABITS-1:0]     q_in_data,
    output logic [ADDRBITS-1:0]     q_in_addr,
    output logic                    q_in_rdreq,
    output logic                    q_in_wrreq,
    output logic [1:0]              q_in_wordlen,
    output logic                    q_push,
    input  logic [DATABITS-1:0]     q_out_data,
    input  logic [ADDRBITS-1:0]     q_out_addr,
    input  logic                    q_out_rdreq,
    input  logic                    q_out_wrreq,
    input  logic [1:0]              q_out_wordlen,
    output logic                    q_pop,
    input  logic                    q_not_empty,
    output logic                    be_req,
    output logic [DATABITS-1:0]     be_data,
    output logic [ADDRBITS-1:0]     be_addr,
    output logic                    be_rdreq,
    output logic                    be_wrreq,
    output logic [1:0]              be_wordlen,
    input  logic                    be_ack,
    input  logic [DATABITS-1:0]     be_rddata,
    output logic                    rsp_valid,
    output logic                    rsp_src,
    output logic [DATABITS-1:0]     rsp_data,
    output logic [QUEUECNTBITS-1:0] q_level
);
    localparam int DEPTH = 2 ** QUEUECNTBITS;
    localparam logic [QUEUECNTBITS-1:0] LVL_FULL = '1;
    localparam logic [QUEUECNTBITS-1:0] ONE      = QUEUECNTBITS'(1);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                  state_q, state_d;
    logic [QUEUECNTBITS-1:0] level_q, level_d;
    logic [QUEUECNTBITS-1:0] wptr_q, wptr_d;
    logic [QUEUECNTBITS-1:0] rptr_q, rptr_d;
    logic [DEPTH-1:0]        ring_q, ring_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_src_q, rsp_src_d;
    logic [DATABITS-1:0]     rsp_data_q, rsp_data_d;
    logic                    a_pend, b_pend, full, win_b, push, pop;

`ifdef DCACHE_QUEUE_CTRL_RR_EN
    logic last_q, last_d;
`endif

    always_comb begin
        a_pend = a_rdreq | a_wrreq;
        b_pend = b_rdreq | b_wrreq;
        full   = (level_q == LVL_FULL);
`ifdef DCACHE_QUEUE_CTRL_RR_EN
        // last_q = 1 means B had the previous grant, so A wins the next conflict
        win_b  = b_pend & (~a_pend | ~last_q);
`else
        win_b  = b_pend & ~a_pend;
`endif
        // Gated by reset so every output reads zero while reset is held
        push   = ~reset & ~full & (a_pend | b_pend);
        a_ack  = push & ~win_b;
        b_ack  = push & win_b;
        q_push = push;

        q_in_data    = '0;
        q_in_addr    = '0;
        q_in_rdreq   = 1'b0;
        q_in_wrreq   = 1'b0;
        q_in_wordlen = '0;
        if (push) begin
            if (win_b) begin
                q_in_data    = b_data;
                q_in_addr    = b_addr;
                q_in_rdreq   = b_rdreq & ~b_wrreq;
                q_in_wrreq   = b_wrreq;
                q_in_wordlen = b_wordlen;
            end else begin
                q_in_data    = a_data;
                q_in_addr    = a_addr;
                q_in_rdreq   = a_rdreq & ~a_wrreq;
                q_in_wrreq   = a_wrreq;
                q_in_wordlen = a_wordlen;
            end
        end
    end

    always_comb begin
        be_req     = 1'b0;
        be_data    = '0;
        be_addr    = '0;
        be_rdreq   = 1'b0;
        be_wrreq   = 1'b0;
        be_wordlen = '0;
        if (state_q == S_ISSUE) begin
            be_req     = 1'b1;
            be_data    = q_out_data;
            be_addr    = q_out_addr;
            be_rdreq   = q_out_rdreq;
            be_wrreq   = q_out_wrreq;
            be_wordlen = q_out_wordlen;
        end
        pop   = (state_q == S_ISSUE) & be_ack;
        q_pop = pop;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if ((level_q != '0) && q_not_empty) state_d = S_ISSUE;
            S_ISSUE: if (be_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase

        // Source ring tracks which requester owns each queue slot
        ring_d = ring_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            ring_d[wptr_q] = win_b;
            wptr_d         = wptr_q + ONE;
        end
        if (pop) rptr_d = rptr_q + ONE;

        rsp_valid_d = pop & q_out_rdreq;
        rsp_src_d   = rsp_src_q;
        rsp_data_d  = rsp_data_q;
        if (rsp_valid_d) begin
            rsp_src_d  = ring_q[rptr_q];
            rsp_data_d = be_rddata;
        end
`ifdef DCACHE_QUEUE_CTRL_RR_EN
        last_d = push ? win_b : last_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            level_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            ring_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_src_q   <= 1'b0;
            rsp_data_q  <= '0;
`ifdef DCACHE_QUEUE_CTRL_RR_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ring_q      <= ring_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_src_q   <= rsp_src_d;
            rsp_data_q  <= rsp_data_d;
`ifdef DCACHE_QUEUE_CTRL_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_data  = rsp_data_q;
    assign q_level   = level_q;

endmodule

// File: tb/tb_dcache_queue_ctrl.sv
// Bench for dcache_queue_ctrl: an 8-slot queue stands in for the external queue; a queue-of-entries model predicts outputs.
module tb_dcache_queue_ctrl;
    localparam int CAP = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_rdreq, a_wrreq, b_rdreq, b_wrreq;
    logic [31:0] a_addr, b_addr, a_data, b_data;
    logic [1:0]  a_wordlen, b_wordlen;
    logic        a_ack, b_ack;
    logic [31:0] q_in_data, q_in_addr, q_out_data, q_out_addr;
    logic        q_in_rdreq, q_in_wrreq, q_out_rdreq, q_out_wrreq;
    logic [1:0]  q_in_wordlen, q_out_wordlen;
    logic        q_push, q_pop, q_not_empty;
    logic        be_req, be_rdreq, be_wrreq, be_ack;
    logic [31:0] be_data, be_addr, be_rddata;
    logic [1:0]  be_wordlen;
    logic        rsp_valid, rsp_src;
    logic [31:0] rsp_data;
    logic [2:0]  q_level;

    dcache_queue_ctrl #(.DATABITS(32), .ADDRBITS(32), .QUEUECNTBITS(3)) dut (
        .clk(clk), .reset(reset),
        .a_rdreq(a_rdreq), .a_wrreq(a_wrreq), .a_addr(a_addr), .a_data(a_data),
        .a_wordlen(a_wordlen), .a_ack(a_ack),
        .b_rdreq(b_rdreq), .b_wrreq(b_wrreq), .b_addr(b_addr), .b_data(b_data),
        .b_wordlen(b_wordlen), .b_ack(b_ack),
        .q_in_data(q_in_data), .q_in_addr(q_in_addr), .q_in_rdreq(q_in_rdreq),
        .q_in_wrreq(q_in_wrreq), .q_in_wordlen(q_in_wordlen), .q_push(q_push),
        .q_out_data(q_out_data), .q_out_addr(q_out_addr), .q_out_rdreq(q_out_rdreq),
        .q_out_wrreq(q_out_wrreq), .q_out_wordlen(q_out_wordlen), .q_pop(q_pop),
        .q_not_empty(q_not_empty),
        .be_req(be_req), .be_data(be_data), .be_addr(be_addr), .be_rdreq(be_rdreq),
        .be_wrreq(be_wrreq), .be_wordlen(be_wordlen), .be_ack(be_ack), .be_rddata(be_rddata),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_data(rsp_data), .q_level(q_level)
    );

    // External queue, reset from the same source as the controller
    logic [31:0] fq_data[8];
    logic [31:0] fq_addr[8];
    logic        fq_rd[8];
    logic        fq_wr[8];
    logic [1:0]  fq_wl[8];
    logic [2:0]  fq_wp, fq_rp;
    logic [3:0]  fq_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fq_wp  <= 3'd0;
            fq_rp  <= 3'd0;
            fq_cnt <= 4'd0;
        end else begin
            if (q_push) begin
                fq_data[fq_wp] <= q_in_data;
                fq_addr[fq_wp] <= q_in_addr;
                fq_rd[fq_wp]   <= q_in_rdreq;
                fq_wr[fq_wp]   <= q_in_wrreq;
                fq_wl[fq_wp]   <= q_in_wordlen;
                fq_wp          <= fq_wp + 3'd1;
            end
            if (q_pop) fq_rp <= fq_rp + 3'd1;
            fq_cnt <= fq_cnt + {3'b000, q_push} - {3'b000, q_pop};
        end
    end

    assign q_out_data    = fq_data[fq_rp];
    assign q_out_addr    = fq_addr[fq_rp];
    assign q_out_rdreq   = fq_rd[fq_rp];
    assign q_out_wrreq   = fq_wr[fq_rp];
    assign q_out_wordlen = fq_wl[fq_rp];
    assign q_not_empty   = (fq_cnt != 4'd0);

    // Reference model: ordered list of enqueued entries plus their owners
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [1:0]  wl;
    } ent_t;

    ent_t  mq[$];
    bit    msrc[$];
    bit    m_busy, m_last, m_rsp_v, m_rsp_src;
    logic [31:0] m_rsp_data;

    logic  e_push, e_aack, e_back, e_pop, e_bereq, e_wb;
    ent_t  e_in, e_be;
    int    e_level;
    ent_t  got_in, got_be;

    assign got_in = {q_in_data, q_in_addr, q_in_rdreq, q_in_wrreq, q_in_wordlen};
    assign got_be = {be_data, be_addr, be_rdreq, be_wrreq, be_wordlen};

    int checks = 0;
    int errors = 0;
    bit a_hold, b_hold;

    task automatic model_reset();
        mq.delete();
        msrc.delete();
        m_busy  = 1'b0;
        m_last  = 1'b0;
        m_rsp_v = 1'b0;
    endtask

    task automatic model_expect();
        logic ap, bp;
        ap = a_rdreq | a_wrreq;
        bp = b_rdreq | b_wrreq;
`ifdef DCACHE_QUEUE_CTRL_RR_EN
        e_wb = bp && (!ap || !m_last);
`else
        e_wb = bp && !ap;
`endif
        e_push = (mq.size() < CAP) && (ap || bp);
        e_aack = e_push && !e_wb;
        e_back = e_push && e_wb;
        e_in   = '0;
        if (e_push) begin
            if (e_wb) e_in = {b_data, b_addr, b_rdreq & ~b_wrreq, b_wrreq, b_wordlen};
            else      e_in = {a_data, a_addr, a_rdreq & ~a_wrreq, a_wrreq, a_wordlen};
        end
        e_bereq = m_busy;
        e_be    = m_busy ? mq[0] : '0;
        e_pop   = m_busy && be_ack;
        e_level = mq.size();
    endtask

    task automatic model_update();
        bit   had;
        ent_t e;
        bit   s;
        had     = (mq.size() != 0);
        m_rsp_v = 1'b0;
        if (e_pop) begin
            e = mq.pop_front();
            s = msrc.pop_front();
            if (e.rd) begin
                m_rsp_v    = 1'b1;
                m_rsp_src  = s;
                m_rsp_data = be_rddata;
            end
        end
        if (e_push) begin
            mq.push_back(e_in);
            msrc.push_back(e_wb);
            m_last = e_wb;
        end
        if (m_busy && be_ack) m_busy = 1'b0;
        else if (!m_busy && had) m_busy = 1'b1;
    endtask

    task automatic drive_idle();
        a_rdreq = 0; a_wrreq = 0; a_addr = 0; a_data = 0; a_wordlen = 0;
        b_rdreq = 0; b_wrreq = 0; b_addr = 0; b_data = 0; b_wordlen = 0;
        be_ack = 0; be_rddata = 0;
    endtask

    task automatic cyc_pre();
        #3;
        model_expect();
    endtask

    task automatic cyc_post();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drain();
        drive_idle();
        be_ack = 1'b1;
        for (int k = 0; k < 60 && (mq.size() != 0 || m_busy); k++) begin
            be_rddata = $urandom;
            cyc_pre();
            cyc_post();
        end
        drive_idle();
        cyc_pre();
        cyc_post();
    endtask

    task automatic gen(input bit rdonly, output logic rd, output logic wr,
                       output logic [31:0] ad, output logic [31:0] dt, output logic [1:0] wl);
        logic [1:0] k;
        k  = rdonly ? 2'b01 : 2'($urandom_range(1, 3));
        rd = k[0];
        wr = k[1];
        ad = $urandom;
        dt = $urandom;
        wl = 2'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        model_reset();
        a_rdreq = 1; b_wrreq = 1; be_ack = 1; a_addr = 32'h55; b_data = 32'h66;
        #2;
        checks++;
        if ({a_ack, b_ack, q_push, q_pop, be_req, rsp_valid} !== 6'b0 || q_level !== 3'd0 || got_in !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b%b push=%b pop=%b be_req=%b rsp=%b lvl=%0d in=%h exp all zero",
                     a_ack, b_ack, q_push, q_pop, be_req, rsp_valid, q_level, got_in);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle();
        cyc_pre();
        checks++;
        if (be_req !== 1'b0 || q_level !== 3'd0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got be_req=%b lvl=%0d rsp=%b exp 0 0 0", be_req, q_level, rsp_valid);
        end
        cyc_post();
    endtask

    task automatic test_a_write();
        drive_idle();
        a_wrreq = 1; a_addr = 32'h100; a_data = 32'hDEADBEEF; a_wordlen = 2'd2;
        cyc_pre();
        checks++;
        if (a_ack !== 1'b1 || q_push !== 1'b1 || got_in !== {32'hDEADBEEF, 32'h100, 1'b0, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL a_write_push got ack=%b push=%b in=%h", a_ack, q_push, got_in);
        end
        cyc_post();
        drive_idle();
        cyc_pre();
        checks++;
        if (be_req !== 1'b0) begin
            errors++;
            $display("FAIL a_write_cycle1 be_req got=%b exp=0", be_req);
        end
        cyc_post();
        be_ack = 1;
        cyc_pre();
        checks++;
        if (be_req !== 1'b1 || got_be !== {32'hDEADBEEF, 32'h100, 1'b0, 1'b1, 2'd2} || q_pop !== 1'b1) begin
            errors++;
            $display("FAIL a_write_issue got be_req=%b be=%h pop=%b", be_req, got_be, q_pop);
        end
        cyc_post();
        be_ack = 0;
        cyc_pre();
        checks++;
        if (rsp_valid !== 1'b0 || q_level !== 3'd0) begin
            errors++;
            $display("FAIL a_write_no_rsp got rsp=%b lvl=%0d exp 0 0", rsp_valid, q_level);
        end
        cyc_post();
    endtask

    task automatic test_b_read();
        drive_idle();
        b_rdreq = 1; b_addr = 32'h200;
        cyc_pre();
        checks++;
        if (b_ack !== 1'b1 || a_ack !== 1'b0 || q_in_rdreq !== 1'b1 || q_in_addr !== 32'h200) begin
            errors++;
            $display("FAIL b_read_push got b_ack=%b a_ack=%b rd=%b addr=%h", b_ack, a_ack, q_in_rdreq, q_in_addr);
        end
        cyc_post();
        drive_idle();
        cyc_pre();
        cyc_post();
        be_ack = 1; be_rddata = 32'h12345678;
        cyc_pre();
        checks++;
        if (be_req !== 1'b1 || be_rdreq !== 1'b1 || be_addr !== 32'h200) begin
            errors++;
            $display("FAIL b_read_issue got be_req=%b rd=%b addr=%h", be_req, be_rdreq, be_addr);
        end
        cyc_post();
        be_ack = 0; be_rddata = 0;
        cyc_pre();
        checks++;
        if ({rsp_valid, rsp_src, rsp_data} !== {1'b1, 1'b1, 32'h12345678}) begin
            errors++;
            $display("FAIL b_read_rsp got v=%b src=%b data=%h exp 1 1 12345678", rsp_valid, rsp_src, rsp_data);
        end
        cyc_post();
        cyc_pre();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b_read_rsp_pulse got=%b exp=0", rsp_valid);
        end
        cyc_post();
    endtask

    task automatic test_full();
        drive_idle();
        for (int i = 0; i < 7; i++) begin
            a_wrreq = 1; a_addr = 32'h1000 + i; a_data = i; a_wordlen = 2'd2;
            cyc_pre();
            checks++;
            if (a_ack !== 1'b1 || q_push !== 1'b1) begin
                errors++;
                $display("FAIL full_fill%0d got ack=%b push=%b exp 1 1", i, a_ack, q_push);
            end
            cyc_post();
        end
        a_addr = 32'h2000;
        for (int k = 0; k < 3; k++) begin
            cyc_pre();
            checks++;
            if (a_ack !== 1'b0 || q_push !== 1'b0 || q_level !== 3'd7) begin
                errors++;
                $display("FAIL full_block%0d got ack=%b push=%b lvl=%0d exp 0 0 7", k, a_ack, q_push, q_level);
            end
            cyc_post();
        end
        be_ack = 1;
        cyc_pre();
        checks++;
        if (q_pop !== 1'b1 || a_ack !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_cycle got pop=%b ack=%b exp 1 0", q_pop, a_ack);
        end
        cyc_post();
        be_ack = 0;
        cyc_pre();
        checks++;
        if (a_ack !== 1'b1 || q_level !== 3'd6) begin
            errors++;
            $display("FAIL full_after_pop got ack=%b lvl=%0d exp 1 6", a_ack, q_level);
        end
        cyc_post();
        drive_idle();
        cyc_pre();
        checks++;
        if (q_level !== 3'd7) begin
            errors++;
            $display("FAIL full_refill lvl got=%0d exp=7", q_level);
        end
        cyc_post();
        drain();
    endtask

    task automatic test_arbitration();
        logic ea;
        drive_idle();
        b_wrreq = 1; b_addr = 32'h300;
        cyc_pre();
        checks++;
        if (b_ack !== 1'b1) begin
            errors++;
            $display("FAIL arb_b_alone got=%b exp=1", b_ack);
        end
        cyc_post();
        drive_idle();
        a_wrreq = 1; a_addr = 32'h400;
        b_wrreq = 1; b_addr = 32'h500;
        for (int k = 0; k < 4; k++) begin
            cyc_pre();
`ifdef DCACHE_QUEUE_CTRL_RR_EN
            ea = (k % 2 == 0);
`else
            ea = 1'b1;
`endif
            checks++;
            if ({a_ack, b_ack} !== {ea, ~ea}) begin
                errors++;
                $display("FAIL arb_grant%0d got a=%b b=%b exp a=%b b=%b", k, a_ack, b_ack, ea, ~ea);
            end
            cyc_post();
        end
        drain();
    endtask

    task automatic test_push_pop_same();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            a_wrreq = 1; a_addr = 32'h700 + i;
            cyc_pre();
            cyc_post();
        end
        a_addr = 32'h777; be_ack = 1;
        cyc_pre();
        checks++;
        if ({q_push, q_pop, q_level} !== {1'b1, 1'b1, 3'd3}) begin
            errors++;
            $display("FAIL pushpop_strobes got push=%b pop=%b lvl=%0d exp 1 1 3", q_push, q_pop, q_level);
        end
        cyc_post();
        drive_idle();
        cyc_pre();
        checks++;
        if (q_level !== 3'd3) begin
            errors++;
            $display("FAIL pushpop_level got=%0d exp=3", q_level);
        end
        cyc_post();
        drain();
    endtask

    task automatic test_reset_mid_issue();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            a_rdreq = 1; a_addr = 32'h600 + i;
            cyc_pre();
            cyc_post();
        end
        drive_idle();
        cyc_pre();
        checks++;
        if (be_req !== 1'b1 || q_level !== 3'd3) begin
            errors++;
            $display("FAIL midrst_setup got be_req=%b lvl=%0d exp 1 3", be_req, q_level);
        end
        reset = 1'b1;
        be_ack = 1'b1;
        be_rddata = 32'hCAFE0001;
        #1;
        checks++;
        if ({be_req, q_pop, rsp_valid} !== 3'b000 || q_level !== 3'd0) begin
            errors++;
            $display("FAIL midrst_async got be_req=%b pop=%b rsp=%b lvl=%0d exp all 0", be_req, q_pop, rsp_valid, q_level);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_idle();
            be_ack = 1'($urandom_range(0, 1));
            cyc_pre();
            checks++;
            if (rsp_valid !== 1'b0 || be_req !== 1'b0 || q_level !== 3'd0) begin
                errors++;
                $display("FAIL midrst_after%0d got rsp=%b be_req=%b lvl=%0d exp 0 0 0", k, rsp_valid, be_req, q_level);
            end
            cyc_post();
        end
    endtask

    task automatic test_src_order();
        bit exp_ord[$];
        bit got_ord[$];
        int enq;
        int bad;
        enq = 0;
        a_hold = 0;
        b_hold = 0;
        drive_idle();
        for (int cyc = 0; cyc < 600 && got_ord.size() < 20; cyc++) begin
            if (!a_hold) begin
                if (enq + int'(b_hold) < 20 && $urandom_range(0, 99) < 70) begin
                    gen(1'b1, a_rdreq, a_wrreq, a_addr, a_data, a_wordlen);
                    a_hold = 1;
                end else begin
                    a_rdreq = 0; a_wrreq = 0;
                end
            end
            if (!b_hold) begin
                if (enq + int'(a_hold) < 20 && $urandom_range(0, 99) < 70) begin
                    gen(1'b1, b_rdreq, b_wrreq, b_addr, b_data, b_wordlen);
                    b_hold = 1;
                end else begin
                    b_rdreq = 0; b_wrreq = 0;
                end
            end
            be_ack = 1'($urandom_range(0, 1));
            be_rddata = $urandom;
            cyc_pre();
            if (rsp_valid === 1'b1) got_ord.push_back(rsp_src);
            if (e_aack) begin exp_ord.push_back(1'b0); a_hold = 0; enq++; end
            if (e_back) begin exp_ord.push_back(1'b1); b_hold = 0; enq++; end
            cyc_post();
        end
        checks++;
        if (got_ord.size() != 20 || exp_ord.size() != 20) begin
            errors++;
            $display("FAIL src_order_count got=%0d exp=20 (enqueued %0d)", got_ord.size(), exp_ord.size());
        end
        bad = 0;
        for (int i = 0; i < 20 && i < got_ord.size() && i < exp_ord.size(); i++)
            if (got_ord[i] != exp_ord[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL src_order_seq got %0d misordered owners exp 0", bad);
        end
        drain();
    endtask

    task automatic test_random(input int cycles);
        int ack_pct;
        a_hold = 0;
        b_hold = 0;
        drive_idle();
        for (int cyc = 0; cyc < cycles; cyc++) begin
            ack_pct = (cyc < cycles / 3) ? 30 : (cyc < 2 * cycles / 3) ? 5 : 70;
            if (!a_hold) begin
                gen(1'b0, a_rdreq, a_wrreq, a_addr, a_data, a_wordlen);
                if ($urandom_range(0, 99) < 60) a_hold = 1;
                else begin a_rdreq = 0; a_wrreq = 0; end
            end
            if (!b_hold) begin
                gen(1'b0, b_rdreq, b_wrreq, b_addr, b_data, b_wordlen);
                if ($urandom_range(0, 99) < 60) b_hold = 1;
                else begin b_rdreq = 0; b_wrreq = 0; end
            end
            be_ack = ($urandom_range(0, 99) < ack_pct);
            be_rddata = $urandom;
            cyc_pre();
            checks++;
            if ({q_push, a_ack, b_ack, q_pop} !== {e_push, e_aack, e_back, e_pop}) begin
                errors++;
                $display("FAIL rnd_strobes cyc%0d got push/aack/back/pop=%b%b%b%b exp=%b%b%b%b",
                         cyc, q_push, a_ack, b_ack, q_pop, e_push, e_aack, e_back, e_pop);
            end
            checks++;
            if (got_in !== e_in) begin
                errors++;
                $display("FAIL rnd_q_in cyc%0d got=%h exp=%h", cyc, got_in, e_in);
            end
            checks++;
            if ({be_req, got_be} !== {e_bereq, e_be}) begin
                errors++;
                $display("FAIL rnd_backend cyc%0d got req=%b %h exp req=%b %h", cyc, be_req, got_be, e_bereq, e_be);
            end
            checks++;
            if (q_level !== 3'(e_level)) begin
                errors++;
                $display("FAIL rnd_level cyc%0d got=%0d exp=%0d", cyc, q_level, e_level);
            end
            checks++;
            if (rsp_valid !== m_rsp_v) begin
                errors++;
                $display("FAIL rnd_rsp_valid cyc%0d got=%b exp=%b", cyc, rsp_valid, m_rsp_v);
            end
            if (m_rsp_v) begin
                checks++;
                if ({rsp_src, rsp_data} !== {m_rsp_src, m_rsp_data}) begin
                    errors++;
                    $display("FAIL rnd_rsp cyc%0d got src=%b data=%h exp src=%b data=%h",
                             cyc, rsp_src, rsp_data, m_rsp_src, m_rsp_data);
                end
            end
            if (e_aack) a_hold = 0;
            if (e_back) b_hold = 0;
            cyc_post();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_a_write();
        test_b_read();
        test_full();
        test_arbitration();
        test_push_pop_same();
        test_reset_mid_issue();
        test_src_order();
        test_random(300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dcache_queue_ctrl.md
DCACHE_QUEUE_CTRL -- requirements
Module: dcache_queue_ctrl
Interface
REQ-001 DATABITS, 32, data width.
REQ-002 ADDRBITS, 32, address width.
REQ-003 QUEUECNTBITS, 3, queue pointer width; usable depth 2**QUEUECNTBITS-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 a_rdreq, b_rdreq  input  1  read request, held until ack.
REQ-007 a_wrreq, b_wrreq  input  1  write request, held until ack.
REQ-008 a_addr, b_addr  input  ADDRBITS  request address.
REQ-009 a_data, b_data  input  DATABITS  write data.
REQ-010 a_wordlen, b_wordlen  input  2  access size code, passed through unchanged.
REQ-011 a_ack, b_ack  output  1  request enqueued this cycle.
REQ-012 q_in_data/addr/rdreq/wrreq/wordlen  output  DATABITS/ADDRBITS/1/1/2  entry to queue.
REQ-013 q_push  output  1  queue write strobe.
REQ-014 q_out_data/addr/rdreq/wrreq/wordlen  input  widths as REQ-012  queue head entry.
REQ-015 q_pop  output  1  queue head advance strobe.
REQ-016 q_not_empty  input  1  queue non-empty flag.
REQ-017 be_req  output  1  backend request, held until be_ack.
REQ-018 be_data/addr/rdreq/wrreq/wordlen  output  widths as REQ-012  head entry to backend.
REQ-019 be_ack  input  1  backend completion, one-cycle pulse.
REQ-020 be_rddata  input  DATABITS  read data, valid with be_ack.
REQ-021 rsp_valid  output  1  read response pulse.
REQ-022 rsp_src  output  1  response owner: 0=A, 1=B.
REQ-023 rsp_data  output  DATABITS  read response data.
REQ-024 q_level  output  QUEUECNTBITS  current queue occupancy.
Function
REQ-025 Occupancy: +1 on q_push alone, -1 on q_pop alone, unchanged on both or neither; full = q_level==2**QUEUECNTBITS-1.
REQ-026 Arbitration combinational: requester pending if rdreq|wrreq; not full and a winner -> q_push=1 and winner's ack=1 same cycle; loser ack=0.
REQ-027 Full: q_push, a_ack, b_ack =0, requests stay pending; simultaneous q_pop does not unblock push that cycle.
REQ-028 rdreq and wrreq both 1: enqueued as write (q_in_rdreq=0, q_in_wrreq=1).
REQ-029 q_in_* = winner's fields on push; all 0 otherwise.
REQ-030 Internal 2**QUEUECNTBITS x 1-bit source ring: written with winner id on q_push, advanced on q_pop, pointers wrap modulo 2**QUEUECNTBITS, lockstep with queue.
REQ-031 Drain FSM IDLE/ISSUE: IDLE->ISSUE when q_level!=0 and q_not_empty=1; ISSUE->IDLE on be_ack.
REQ-032 ISSUE: be_req=1, be_* = q_out_*; IDLE: be_req=0, be_* = 0.
REQ-033 be_ack in ISSUE -> q_pop=1 same cycle; be_ack in IDLE ignored; q_pop never asserted otherwise.
REQ-034 be_ack on read entry -> next cycle rsp_valid=1 for one cycle, rsp_src=ring head, rsp_data=registered be_rddata; writes give no response.
REQ-035 Latency: push in cycle N into empty queue -> be_req from cycle N+2; max one backend transaction per 2 cycles.
Reset
REQ-036 reset=1: q_level 0, FSM IDLE, ring pointers 0, rsp_valid/rsp_src/rsp_data 0, last-grant = A; all outputs 0.
REQ-037 Reset during ISSUE: be_req drops asynchronously, transaction abandoned, no pop, no response.
REQ-038 Queue reset driven from same source (reset_n = ~reset) so pointers agree; FSM leaves IDLE no earlier than first clk edge after release.
Configuration
REQ-039 DCACHE_QUEUE_CTRL_RR_EN defined: round-robin; 1-bit last-grant register updated on each push; on conflict the requester not last granted wins.
REQ-040 DCACHE_QUEUE_CTRL_RR_EN undefined: fixed priority, A always wins, B granted only when A idle; no last-grant register.
Verification
REQ-041 A write 0x100/0xDEADBEEF/wordlen 2, empty queue -> a_ack cycle 0, be_req cycle 2 same fields; be_ack -> q_pop, no rsp_valid.
REQ-042 B read 0x200, be_ack with be_rddata 0x12345678 -> next cycle rsp_valid=1, rsp_src=1, rsp_data=0x12345678.
REQ-043 be_ack held 0, A issues 8 writes -> 7 acked, q_level=7, 8th unacked until one pop, then acked cycle after pop.
REQ-044 A and B pending 4 cycles, backend stalled -> with RR_EN grants A,B,A,B; without, A,A,A,A and b_ack=0.
REQ-045 reset pulsed mid-ISSUE with 3 entries -> be_req 0 immediately, q_level 0, no rsp_valid after release.
REQ-046 push+pop same cycle at q_level 3 -> stays 3; 20 mixed A/B reads across wrap -> rsp_src order equals enqueue order.
